// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter in front of the select input of an 8:1 bit multiplexer.
// Requester i owns mux input a[i]. The winner's index drives the mux select
// and stays stable for the whole tenure. Every hand-over passes through one
// idle cycle, so the mux never switches directly from one owner to the next.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   req      in   N      level request, one bit per requester
//   done     in   1      owner finished (1-cycle pulse), looked at only in GRANT
//   grant    out  N      one-hot grant to the current owner, zero when idle
//   sel      out  SEL_W  mux select, index of the grant bit (held while idle)
//   busy     out  1      high while a tenure is in progress
//   timeout  out  1      1-cycle pulse when a tenure is cut off by MAX_HOLD
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam int             CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [N-1:0]   GNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [N-1:0]     grant_q;
  logic [SEL_W-1:0] sel_q;
  logic             busy_q;
  logic             timeout_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [SEL_W-1:0] win_idx_d;
  logic             end_done;
  logic             end_drop;
  logic             end_max;
  logic             tenure_end;
  logic             timeout_d;

  // First set request bit at or after p, wrapping around. The loop runs from
  // the farthest offset down to p itself so the nearest hit is the last write.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0]     r,
                                                input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    rr_pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign win_idx_d  = rr_pick(req, ptr_q);

  assign end_done   = done;
  assign end_drop   = ~req[sel_q];
  assign end_max    = (hold_cnt_q == HOLD_LAST);
  assign tenure_end = end_done | end_drop | end_max;
  // A forced release is reported only when the owner did not end it itself.
  assign timeout_d  = end_max & ~end_done & ~end_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // sel is deliberately left alone here so the mux does not glitch.
          if (|req) begin
            state_q    <= GRANT;
            grant_q    <= GNT_ONE << win_idx_d;
            sel_q      <= win_idx_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= sel_q + SEL_W'(1);
            timeout_q <= timeout_d;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Bench for mux8_rr_arbiter. Each cycle the applied inputs are fed into a
// behavioural reference of the arbiter; the predicted outputs are queued and
// compared after the following rising edge. Directed scenarios add explicit
// expectations on top of the reference.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  mux8_rr_arbiter #(
    .N        (8),
    .SEL_W    (3),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       t;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic       m_busy;
  logic [7:0] m_grant;
  int         m_sel;
  int         m_ptr;
  int         m_hold;
  logic       m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 8'h00;
    m_sel   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, output exp_t e);
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        int w;
        w = m_ptr;
        while (r[w] == 1'b0) w = (w + 1) % 8;
        m_grant = 8'h01 << w;
        m_sel   = w;
        m_busy  = 1'b1;
        m_hold  = 0;
      end
    end else begin
      logic rel_done;
      logic rel_drop;
      logic rel_max;
      rel_done = d;
      rel_drop = (r[m_sel] == 1'b0);
      rel_max  = (m_hold == MAX_HOLD - 1);
      if (rel_done || rel_drop || rel_max) begin
        m_grant = 8'h00;
        m_busy  = 1'b0;
        m_ptr   = (m_sel + 1) % 8;
        m_to    = rel_max && !rel_done && !rel_drop;
      end else begin
        m_hold = m_hold + 1;
      end
    end
    e.g = m_grant;
    e.s = 3'(m_sel);
    e.b = m_busy;
    e.t = m_to;
  endtask

  // Apply inputs for one cycle, predict, then compare after the edge.
  task automatic cyc(input logic [7:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    model_step(r, d, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("grant",   32'(grant),   32'(e.g));
    chk("sel",     32'(sel),     32'(e.s));
    chk("busy",    32'(busy),    32'(e.b));
    chk("timeout", 32'(timeout), 32'(e.t));
    chk("onehot",  32'($countones(grant) <= 1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n08;
    int   nto;
    logic saw20;
    logic [7:0] rr;
    logic       dd;

    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant",   32'(grant),   32'h00);
    chk("rst_sel",     32'(sel),     32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;

    // single requester, released by done
    cyc(8'h00, 1'b0);
    cyc(8'h01, 1'b0);
    chk("t1_grant", 32'(grant), 32'h01);
    cyc(8'h01, 1'b1);
    chk("t1_release", 32'(grant), 32'h00);
    cyc(8'h00, 1'b1);   // done while idle is ignored
    cyc(8'h00, 1'b0);

    // all requesting, done every tenure: rotation with one idle cycle between
    for (int k = 0; k < 8; k++) begin
      cyc(8'hFF, 1'b0);
      chk("rr_grant", 32'(grant), 32'(8'h01 << ((1 + k) % 8)));
      cyc(8'hFF, 1'b1);
      chk("rr_gap", 32'(grant), 32'h00);
    end
    cyc(8'h00, 1'b0);

    // wrap-around: tenure of 6 leaves ptr at 7
    cyc(8'h40, 1'b0);
    cyc(8'h40, 1'b1);
    cyc(8'h81, 1'b0);
    chk("wrap_80", 32'(grant), 32'h80);
    cyc(8'h81, 1'b1);
    cyc(8'h81, 1'b0);
    chk("wrap_01", 32'(grant), 32'h01);
    cyc(8'h81, 1'b1);
    cyc(8'h00, 1'b0);

    // owner 3 never finishes: forced release after MAX_HOLD cycles
    n08   = 0;
    nto   = 0;
    saw20 = 1'b0;
    for (int i = 0; i < 26; i++) begin
      cyc(8'h28, 1'b0);
      if (grant == 8'h08) n08++;
      if (timeout) nto++;
      if (grant == 8'h20) saw20 = 1'b1;
    end
    chk("hold_cycles",   32'(n08),   32'd16);
    chk("timeout_count", 32'(nto),   32'd1);
    chk("next_served",   32'(saw20), 32'd1);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // owner 5 drops its request while 2 is pending
    cyc(8'h20, 1'b0);
    chk("drop_own", 32'(grant), 32'h20);
    cyc(8'h24, 1'b0);
    chk("drop_hold", 32'(grant), 32'h20);
    cyc(8'h04, 1'b0);
    chk("drop_rel", 32'(grant), 32'h00);
    cyc(8'h04, 1'b0);
    chk("drop_next", 32'(grant), 32'h04);
    cyc(8'h04, 1'b1);

    // randomised traffic; request sets persist for a while, done is sparse
    rr = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) rr = 8'($urandom_range(255));
      dd = ($urandom_range(9) == 0);
      cyc(rr, dd);
    end
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    // asynchronous reset mid-tenure; set ptr to 5 first
    cyc(8'h10, 1'b0);
    cyc(8'h10, 1'b1);
    cyc(8'h10, 1'b0);
    chk("pre_rst_grant", 32'(grant), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h00);
    chk("async_busy",  32'(busy),  32'h0);
    chk("async_sel",   32'(sel),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h30, 1'b0);
    chk("post_rst_ptr0", 32'(grant), 32'h10);
    cyc(8'h30, 1'b1);
    cyc(8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
